// File: rtl/i2c_tx_arbiter_pkg.sv
// Shared definitions for the I2C TX-FIFO write-port arbiter.
// A TX word is {stop, start, data[7:0]}.
package i2c_tx_arbiter_pkg;

    localparam int TXW_W        = 10;
    localparam int TXW_STOP     = 9;
    localparam int TXW_START    = 8;
    localparam int TXW_DATA_MSB = 7;
    localparam int TXW_DATA_LSB = 0;

    typedef logic [TXW_DATA_MSB:TXW_DATA_LSB] txw_data_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    function automatic logic txw_is_stop(input logic [TXW_W-1:0] w);
        return w[TXW_STOP];
    endfunction

    function automatic logic txw_is_start(input logic [TXW_W-1:0] w);
        return w[TXW_START];
    endfunction

endpackage

// File: rtl/i2c_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping,
// using a masked lowest-set-bit search so no variable indexing is needed.
module i2c_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] mask_s;
    logic [N-1:0] hi_s;
    logic [N-1:0] src_s;

    // Prefer requests at or above the pointer; fall back to the whole vector.
    always_comb begin
        mask_s = ~((ONE << ptr) - ONE);
        hi_s   = req & mask_s;
        src_s  = (|hi_s) ? hi_s : req;
        win    = src_s & (~src_s + ONE);
        any    = |req;
    end

endmodule

// File: rtl/i2c_tx_arbiter.sv
// Transaction-granular arbiter for the I2C master TX-FIFO write port.
// One requester owns the port from START to STOP; round-robin, stall timeout, abort.
module i2c_tx_arbiter
    import i2c_tx_arbiter_pkg::*;
#(
    parameter int              NREQ    = 4,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd1000
) (
    input  logic                  ip_clk,
    input  logic                  rst_an,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*TXW_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  tx_full,
    output logic                  tx_wr,
    output logic [TXW_W-1:0]      tx_di,
    input  logic                  arb_fail,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [NREQ-1:0]       abort,
    output logic                  sts_timeout,
    input  logic                  sts_clr
);
    localparam int              PTR_W   = $clog2(NREQ);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_ONE;
    localparam logic            TO_EN   = (TIMEOUT != '0);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [NREQ-1:0]   abort_q, abort_d;
    logic              sts_timeout_q, sts_timeout_d;

    logic [NREQ-1:0]   cand_s;
    logic [NREQ-1:0]   pick_win_s;
    logic              pick_any_s;
    logic              own_valid_s;
    logic [TXW_W-1:0]  own_word_s;
    logic [PTR_W-1:0]  owner_idx_s;
    logic [PTR_W-1:0]  next_ptr_s;
    logic              to_hit_s;

    // Start candidates, owner's word/index and the post-owner rr pointer.
    always_comb begin
        cand_s      = '0;
        own_word_s  = '0;
        owner_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s[i]   = req_valid[i] & txw_is_start(req_data[i*TXW_W +: TXW_W]);
            own_word_s  = own_word_s | (req_data[i*TXW_W +: TXW_W] & {TXW_W{grant_q[i]}});
            owner_idx_s = owner_idx_s | (grant_q[i] ? PTR_W'(i) : '0);
        end
        own_valid_s = |(req_valid & grant_q);
        next_ptr_s  = (owner_idx_s == PTR_W'(NREQ - 1)) ? '0 : owner_idx_s + PTR_W'(1);
    end

    i2c_rr_pick #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_pick (
        .req (cand_s),
        .ptr (rr_ptr_q),
        .win (pick_win_s),
        .any (pick_any_s)
    );

    // FSM next state, timeout counter and the same-cycle FIFO write path.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        to_cnt_d      = to_cnt_q;
        abort_d       = '0;
        sts_timeout_d = sts_timeout_q;
        req_ready     = '0;
        tx_wr         = 1'b0;
        tx_di         = '0;
        to_hit_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && pick_any_s) begin
                    state_d  = ST_LOCK;
                    grant_d  = pick_win_s;
                    to_cnt_d = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOCK: begin
                to_hit_s = TO_EN && !own_valid_s && (to_cnt_q == TO_LAST);
                // An abort cycle kills the offered word: ready stays low.
                if (arb_fail || to_hit_s) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    abort_d  = grant_q;
                    rr_ptr_d = next_ptr_s;
                    to_cnt_d = '0;
                end else begin
                    req_ready = grant_q & {NREQ{!tx_full}};
                    if (own_valid_s && !tx_full) begin
                        tx_wr    = 1'b1;
                        tx_di    = own_word_s;
                        to_cnt_d = '0;
                        if (txw_is_stop(own_word_s)) begin
                            state_d  = ST_IDLE;
                            grant_d  = '0;
                            rr_ptr_d = next_ptr_s;
                        end else begin
                            state_d  = ST_LOCK;
                        end
                    end else if (!own_valid_s) begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end else begin
                        to_cnt_d = to_cnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (to_hit_s) begin
            sts_timeout_d = 1'b1;
        end else if (sts_clr) begin
            sts_timeout_d = 1'b0;
        end else begin
            sts_timeout_d = sts_timeout_q;
        end
    end

    // State and status registers.
    always_ff @(posedge ip_clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            to_cnt_q      <= '0;
            abort_q       <= '0;
            sts_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            to_cnt_q      <= to_cnt_d;
            abort_q       <= abort_d;
            sts_timeout_q <= sts_timeout_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q == ST_LOCK);
    assign abort       = abort_q;
    assign sts_timeout = sts_timeout_q;

endmodule

// File: tb/tb_i2c_tx_arbiter.sv
// Scoreboard bench for i2c_tx_arbiter: directed scenarios plus randomized
// rounds whose expected FIFO word order comes from a round-robin queue model.
module tb_i2c_tx_arbiter;
    localparam int NREQ = 4;

    logic                 ip_clk;
    logic                 rst_an;
    logic                 enable;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*10-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_full;
    logic                 tx_wr;
    logic [9:0]           tx_di;
    logic                 arb_fail;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic [NREQ-1:0]      abort;
    logic                 sts_timeout;
    logic                 sts_clr;

    typedef struct {
        int         owner;
        logic [9:0] word;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] txq [NREQ][$];
    logic [NREQ-1:0] started;
    int         mptr;
    int         n_cmp;
    int         n_err;
    int         to_first;

    i2c_tx_arbiter #(
        .NREQ    (NREQ),
        .TO_W    (16),
        .TIMEOUT (16'd1000)
    ) dut (
        .ip_clk      (ip_clk),
        .rst_an      (rst_an),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_full     (tx_full),
        .tx_wr       (tx_wr),
        .tx_di       (tx_di),
        .arb_fail    (arb_fail),
        .grant       (grant),
        .busy        (busy),
        .abort       (abort),
        .sts_timeout (sts_timeout),
        .sts_clr     (sts_clr)
    );

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ip_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge ip_clk);
    endtask

    task automatic exp_push(input int o, input logic [9:0] w);
        exp_t e;
        e.owner = o;
        e.word  = w;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [9:0] w);
        req_valid[i]       = 1'b1;
        req_data[i*10 +: 10] = w;
    endtask

    task automatic clr_req(input int i);
        req_valid[i]       = 1'b0;
        req_data[i*10 +: 10] = 10'h000;
    endtask

    // Owners may drop valid for a cycle once their START is in; waiting requesters never do.
    task automatic apply_drive();
        for (int i = 0; i < NREQ; i++) begin
            if (txq[i].size() > 0 && !(started[i] && $urandom_range(0, 3) == 0)) begin
                set_req(i, txq[i][0]);
            end else begin
                clr_req(i);
            end
        end
        tx_full = ($urandom_range(0, 3) == 0);
        enable  = ($urandom_range(0, 4) != 0);
    endtask

    // One round: every active requester queues one transaction; the model orders
    // them by walking the requesters from the rr pointer.
    task automatic run_round(input logic [NREQ-1:0] act, input int maxw);
        int n;
        int idx;
        int last;
        logic [9:0] w;
        logic [NREQ-1:0] acc;
        int pend;
        last = mptr;
        for (int i = 0; i < NREQ; i++) begin
            txq[i].delete();
            started[i] = 1'b0;
            if (act[i]) begin
                n = $urandom_range(1, maxw);
                for (int k = 0; k < n; k++) begin
                    w[7:0] = 8'($urandom);
                    w[8]   = (k == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
                    w[9]   = (k == n - 1);
                    txq[i].push_back(w);
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (act[idx]) begin
                for (int j = 0; j < txq[idx].size(); j++) exp_push(idx, txq[idx][j]);
                last = idx;
            end
        end
        mptr = (last + 1) % NREQ;
        apply_drive();
        pend = 1;
        for (int c = 0; c < 3000 && pend != 0; c++) begin
            smp();
            acc = req_valid & req_ready;
            step();
            pend = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    void'(txq[i].pop_front());
                    started[i] = 1'b1;
                end
                pend = pend + txq[i].size();
            end
            apply_drive();
        end
        chk("round_complete", 32'(pend), 32'd0);
        req_valid = '0;
        req_data  = '0;
        tx_full   = 1'b0;
        enable    = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every FIFO write and checks invariants.
    initial begin
        forever begin
            @(negedge ip_clk);
            if (tx_wr) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected_write: actual=%0h required=none t=%0t", tx_di, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_data", 32'(tx_di), 32'(mon_e.word));
                    chk("sb_ready", 32'(req_ready), 32'd1 << mon_e.owner);
                    chk("sb_grant", 32'(grant), 32'd1 << mon_e.owner);
                end
            end else begin
                chk("idle_tx_di_zero", 32'(tx_di), 32'd0);
            end
            chk("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("inv_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            chk("inv_wr_busy", 32'(!tx_wr || busy), 32'd1);
            chk("inv_busy_grant", 32'(busy), 32'(|grant));
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; mptr = 0; to_first = 0;
        rst_an = 1'b0; enable = 1'b1; tx_full = 1'b0; arb_fail = 1'b0; sts_clr = 1'b0;
        req_valid = '0; req_data = '0; started = '0;
        repeat (3) smp();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_sts", 32'(sts_timeout), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_wr", 32'(tx_wr), 32'd0);
        step();
        rst_an = 1'b1;

        // Round robin: 0, 2, 3 then 0 again.
        run_round(4'b1101, 1);
        run_round(4'b0001, 1);

        // Single three-word transaction from requester 1.
        exp_push(1, 10'h1A0); exp_push(1, 10'h055); exp_push(1, 10'h2AA);
        step(); set_req(1, 10'h1A0);
        smp(); chk("t1_idle_ready", 32'(req_ready), 32'd0); chk("t1_idle_grant", 32'(grant), 32'd0);
        step(); smp(); chk("t1_grant", 32'(grant), 32'h2); chk("t1_wr0", 32'(tx_wr), 32'd1);
        step(); set_req(1, 10'h055); smp(); chk("t1_wr1", 32'(tx_wr), 32'd1);
        step(); set_req(1, 10'h2AA); smp(); chk("t1_wr2", 32'(tx_wr), 32'd1);
        step(); clr_req(1); smp(); chk("t1_idle_busy", 32'(busy), 32'd0); chk("t1_idle_grant2", 32'(grant), 32'd0);
        mptr = 2;

        // No interleave: owner 0 stalls while requester 1 waits.
        exp_push(0, 10'h1B0); exp_push(0, 10'h211); exp_push(1, 10'h3C1);
        step(); set_req(0, 10'h1B0);
        smp(); step(); smp(); chk("t3_grant0", 32'(grant), 32'h1);
        step(); clr_req(0); set_req(1, 10'h3C1);
        for (int k = 0; k < 5; k++) begin
            smp(); chk("t3_ready1_low", 32'(req_ready[1]), 32'd0); chk("t3_no_wr", 32'(tx_wr), 32'd0);
            step();
        end
        set_req(0, 10'h211); smp(); chk("t3_stop_wr", 32'(tx_wr), 32'd1);
        step(); clr_req(0); smp(); chk("t3_idle_gap", 32'(grant), 32'd0);
        step(); smp(); chk("t3_grant1", 32'(grant), 32'h2); chk("t3_wr1", 32'(tx_wr), 32'd1);
        step(); clr_req(1); smp(); chk("t3_done", 32'(busy), 32'd0);
        mptr = 2;

        // Backpressure never times out.
        exp_push(2, 10'h1D0); exp_push(2, 10'h2D1);
        step(); tx_full = 1'b1; set_req(2, 10'h1D0);
        smp(); step(); smp(); chk("bp_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 2000; k++) begin
            step(); smp();
            chk("bp_no_wr", 32'(tx_wr), 32'd0);
            chk("bp_no_abort", 32'(abort), 32'd0);
        end
        step(); tx_full = 1'b0; smp(); chk("bp_release_wr", 32'(tx_wr), 32'd1);
        step(); set_req(2, 10'h2D1); smp(); chk("bp_stop_wr", 32'(tx_wr), 32'd1);
        step(); clr_req(2); smp(); chk("bp_done", 32'(busy), 32'd0); chk("bp_sts", 32'(sts_timeout), 32'd0);
        mptr = 3;

        // Timeout: sts_clr held high across the hit, so set must win.
        exp_push(3, 10'h1E0);
        step(); set_req(3, 10'h1E0);
        smp(); step(); smp(); chk("to_grant", 32'(grant), 32'h8);
        step(); clr_req(3); sts_clr = 1'b1;
        for (int n = 1; n <= 1100 && to_first == 0; n++) begin
            smp();
            if (n == 1000) chk("to_locked_before", 32'(busy), 32'd1);
            if (abort != '0) begin
                to_first = n;
                chk("to_abort_owner", 32'(abort), 32'h8);
                chk("to_grant_clear", 32'(grant), 32'd0);
                chk("to_sts_set_wins", 32'(sts_timeout), 32'd1);
            end
            step();
        end
        chk("to_abort_cycle", 32'(to_first), 32'd1001);
        smp(); chk("to_abort_once", 32'(abort), 32'd0); chk("to_sts_cleared", 32'(sts_timeout), 32'd0);
        step(); sts_clr = 1'b0;
        mptr = 0;

        // arb_fail kills the offered word; next rr requester follows.
        exp_push(0, 10'h1F0); exp_push(2, 10'h3F2);
        step(); set_req(0, 10'h1F0); set_req(2, 10'h3F2);
        smp(); step(); smp(); chk("af_grant0", 32'(grant), 32'h1);
        step(); set_req(0, 10'h0AB); arb_fail = 1'b1;
        smp(); chk("af_ready_low", 32'(req_ready), 32'd0); chk("af_no_wr", 32'(tx_wr), 32'd0);
        step(); arb_fail = 1'b0; clr_req(0);
        smp(); chk("af_abort", 32'(abort), 32'h1); chk("af_grant_clear", 32'(grant), 32'd0);
        chk("af_no_sts", 32'(sts_timeout), 32'd0);
        step(); smp(); chk("af_next_grant", 32'(grant), 32'h4); chk("af_abort_once", 32'(abort), 32'd0);
        step(); clr_req(2);
        step(); arb_fail = 1'b1; smp();
        step(); arb_fail = 1'b0; smp();
        chk("af_idle_ignored", 32'(abort), 32'd0); chk("af_idle_busy", 32'(busy), 32'd0);
        mptr = 3;

        // enable gates new grants only.
        exp_push(1, 10'h1C5); exp_push(1, 10'h2C6);
        step(); enable = 1'b0; set_req(1, 10'h1C5);
        for (int k = 0; k < 3; k++) begin
            smp(); chk("en_no_grant", 32'(busy), 32'd0); chk("en_no_ready", 32'(req_ready), 32'd0);
            step();
        end
        enable = 1'b1; smp(); step(); enable = 1'b0;
        smp(); chk("en_grant", 32'(grant), 32'h2); chk("en_wr0", 32'(tx_wr), 32'd1);
        step(); set_req(1, 10'h2C6); smp(); chk("en_wr_stop", 32'(tx_wr), 32'd1);
        step(); clr_req(1); enable = 1'b1; smp(); chk("en_done", 32'(busy), 32'd0);
        mptr = 2;

        for (int r = 0; r < 40; r++) begin
            run_round(4'($urandom_range(1, 15)), 4);
        end

        repeat (5) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_tx_arbiter.md
Name: i2c_tx_arbiter

Overview:
- Shares the single I2C master transmit-FIFO write port among NREQ on-chip requesters, for example the APB path, a DMA engine and a sensor poller.
- Grants the port at I2C-transaction granularity: locked from an accepted START word until an accepted STOP word, so words from different requesters never interleave on the bus.
- Includes round-robin fairness, a stall timeout and abort on arbitration loss.
- Sits in the ip_clk domain, directly in front of the TX FIFO write side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TO_W, 16, width of the stall-timeout counter.
- TIMEOUT, 16'd1000, number of idle owner cycles in LOCK before abort; 0 disables the timeout.

Ports:
- ip_clk  in  1  clock.
- rst_an  in  1  reset, asynchronous, active-low.
- enable  in  1  allow new grants; when 0, an in-progress transaction still completes.
- req_valid  in  NREQ  requester i has a TX word.
- req_data  in  NREQ*10  word i at [i*10+:10] = {stop[9], start[8], data[7:0]}.
- req_ready  out  NREQ  word i accepted this cycle when valid&ready.
- tx_full  in  1  TX FIFO full.
- tx_wr  out  1  TX FIFO write strobe (active high).
- tx_di  out  10  TX FIFO write data.
- arb_fail  in  1  one-cycle pulse: master lost bus arbitration.
- grant  out  NREQ  one-hot current owner (0 in IDLE).
- busy  out  1  state==LOCK.
- abort  out  NREQ  one-cycle pulse to the owner whose transaction was killed.
- sts_timeout  out  1  sticky: a timeout abort occurred.
- sts_clr  in  1  clears sts_timeout.

Behaviour:
- Reset values: state IDLE; grant=0, busy=0, abort=0, sts_timeout=0, rr pointer=0, timeout counter=0, req_ready=0.
- tx_wr=0 and tx_di=0 whenever no word is accepted.

State IDLE:
- Candidates are requesters with req_valid=1 and req_data start bit=1.
- Words without the start bit are never accepted in IDLE (ready=0).
- If enable=1 and any candidate exists: pick the first candidate at or after the rr pointer (wrapping at NREQ-1→0).
- Register grant one-hot; go to LOCK next cycle.
- Nothing is written in the grant cycle. First acceptance is at the earliest 1 cycle after req_valid.

State LOCK:
- req_ready[owner] = !tx_full. All other ready bits are 0.
- tx_wr = req_valid[owner] & !tx_full, combinational, same cycle.
- tx_di = owner's word, passed through unmodified.
- A START word inside LOCK (repeated start) is accepted; the state stays LOCK.
- An accepted word with stop=1 gives, next cycle: IDLE, grant=0, rr pointer = owner+1 mod NREQ.
- A word with both start and stop set ends the transaction.

Timeout:
- Counter clears on every accepted word and on entry to LOCK.
- Increments when req_valid[owner]=0.
- Holds while tx_full=1 and req_valid[owner]=1; FIFO backpressure never times out.
- When counter==TIMEOUT-1 and it would increment: abort.

Abort (arb_fail=1, or timeout):
- Next cycle: IDLE, grant=0, abort[owner]=1 for exactly one cycle, rr pointer = owner+1.
- If the abort cause was the timeout, sts_timeout←1.
- The word offered in the abort cycle is NOT accepted: ready forced to 0 in that cycle.
- arb_fail in IDLE is ignored; no abort pulse.

Status and enable:
- sts_clr and a same-cycle timeout set: set wins.
- enable dropping in LOCK has no effect until the STOP word or an abort.
- Asynchronous reset mid-transaction returns to IDLE immediately. The FIFO owner must flush separately; the FIFO is reset by the same domain.

Invariants:
- grant is always one-hot or zero.
- tx_wr implies busy.
- At most one ready bit is high.

Decomposition:
- Shared defs file: TX word bit indices TXW_STOP=9, TXW_START=8, TXW_DATA=7:0; state encodings ST_IDLE=1'b0, ST_LOCK=1'b1.
- Sub-module i2c_rr_pick: combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: one-hot winner and any.
- Arbiter top holds the FSM, the timeout counter and the datapath mux.

Test Plan:
- Single transaction: NREQ=4, req1 sends 3FF-free sequence 0x1A0 (start, addr 0xA0), 0x055, 0x2AA (stop) with tx_full=0 → grant=0010 one cycle after valid; tx_wr on 3 consecutive cycles with tx_di=1A0, 055, 2AA; IDLE next cycle; rr pointer=2.
- Round-robin: req0, req2 and req3 all valid with start, pointer=0, each sending 1-word start+stop 0x3xx → grant order 0, 2, 3, then back to 0 when req0 is re-requested.
- No interleave: req0 locked and stalls valid for 5 cycles while req1 is valid → req_ready[1] stays 0; no tx_wr from req1 until req0's STOP is accepted.
- Backpressure: tx_full=1 for 2000 cycles while the owner is valid, TIMEOUT=1000 → no abort; tx_wr=0 throughout; word written in the cycle tx_full drops.
- Timeout: owner valid low for 1000 cycles in LOCK → abort[owner] pulses once; sts_timeout=1; grant=0; sts_clr → sts_timeout=0.
- arb_fail: pulse mid-transaction while the owner offers a word → word not accepted; abort pulse; next requester in rr order is granted the following IDLE cycle. arb_fail pulsed in IDLE → no effect.
